// File: rtl/ps2_key_receiver.sv
// Receive-only PS/2 keyboard front end: sync, glitch filter, 11-bit framer.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity or stop bit.
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    inout  wire        ps2_clock,
    inout  wire        ps2_data,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    csync_q;
    logic [1:0]    dsync_q;
    logic          filt_q;
    logic [FW-1:0] fcnt_q;
    logic [3:0]    bit_q;
    logic [8:0]    shift_q;
    logic [TW-1:0] idle_q;
    logic [7:0]    key_q;
    logic [7:0]    out_q;
    logic          strobe_q;
    logic          fall;
    logic          frame_ok;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csync_q <= 2'b11;
            dsync_q <= 2'b11;
        end else begin
            csync_q <= {csync_q[0], ps2_clock};
            dsync_q <= {dsync_q[0], ps2_data};
        end
    end

    // Level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (csync_q[1] == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q <= csync_q[1];
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign fall = filt_q & ~csync_q[1] &
                  (fcnt_q == FW'(FILTER_LEN - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = dsync_q[1] & (^shift_q);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bit_q    <= '0;
            shift_q  <= '0;
            idle_q   <= '0;
            key_q    <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (fall) begin
                idle_q <= '0;
                if (bit_q == 4'd0) begin
                    if (!dsync_q[1])
                        bit_q <= 4'd1;
                end else if (bit_q == 4'd10) begin
                    bit_q <= '0;
                    if (frame_ok) begin
                        key_q    <= shift_q[7:0];
                        out_q    <= shift_q[7:0];
                        strobe_q <= 1'b1;
                    end
                end else begin
                    // Data LSB first, then parity lands in bit 8.
                    shift_q <= {dsync_q[1], shift_q[8:1]};
                    bit_q   <= bit_q + 4'd1;
                end
            end else if (idle_q != TW'(TIMEOUT_CYCLES)) begin
                idle_q <= idle_q + 1'b1;
            end else if (bit_q != 4'd0) begin
                bit_q <= '0;
            end
        end
    end

    assign ps2_key_data    = key_q;
    assign ps2_out         = out_q;
    assign ps2_key_pressed = strobe_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Randomized scoreboard bench for ps2_key_receiver.
module tb_ps2_key_receiver;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ps2_c;
    logic       ps2_d;
    wire        ps2_c_w;
    wire        ps2_d_w;
    logic [7:0] key_data;
    logic       pressed;
    logic [7:0] ps2_out;

    assign ps2_c_w = ps2_c;
    assign ps2_d_w = ps2_d;

    always #5 clk = ~clk;

    ps2_key_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock          (clk),
        .resetn         (resetn),
        .ps2_clock      (ps2_c_w),
        .ps2_data       (ps2_d_w),
        .ps2_key_data   (key_data),
        .ps2_key_pressed(pressed),
        .ps2_out        (ps2_out)
    );

    logic [7:0] exp_q[$];
    logic [7:0] last_acc;
    int         total = 0;
    int         passed = 0;
    logic       prev_pressed = 1'b0;

    function automatic bit accepts(input logic [7:0] b, input logic par,
                                   input logic stop);
`ifdef PS2_PARITY_CHECK_EN
        return stop && ((($countones(b) + int'(par)) % 2) == 1);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (resetn && pressed) begin
            total++;
            if (prev_pressed)
                $display("FAIL strobe_back_to_back: got 1 expected 0");
            else
                passed++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: got %0h expected none",
                         key_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("strobe_key_data", key_data, e);
                check("strobe_ps2_out", ps2_out, e);
            end
        end
        prev_pressed = pressed;
    end

    task automatic send_bit(input logic b);
        ps2_d = b;
        repeat (HALF) @(posedge clk);
        ps2_c = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_c = 1'b1;
    endtask

    task automatic check_out(input string tag);
        @(negedge clk);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_ps2_out"}, ps2_out, last_acc);
        check({tag, "_key_data"}, key_data, last_acc);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input logic stop, input string tag);
        if (accepts(b, par, stop)) begin
            exp_q.push_back(b);
            last_acc = b;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        repeat (60) @(posedge clk);
        check_out(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rp;
        logic       rs;
        resetn   = 1'b0;
        ps2_c    = 1'b1;
        ps2_d    = 1'b1;
        last_acc = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_key_data", key_data, 0);
        check("reset_ps2_out", ps2_out, 0);
        check("reset_pressed", pressed, 0);
        @(posedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);

        send_frame(8'h1C, 1'b0, 1'b1, "basic_1C");
        send_frame(8'h1C, 1'b1, 1'b1, "badpar_1C");
        send_frame(8'hF0, 1'b1, 1'b1, "F0");

        // Partial frame abandoned by the idle timeout.
        for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
        repeat (TO + 100) @(posedge clk);
        send_frame(8'h5A, 1'b1, 1'b1, "timeout_5A");

        // Short low glitch with data low would look like a start bit.
        ps2_d = 1'b0;
        ps2_c = 1'b0;
        repeat (3) @(posedge clk);
        ps2_c = 1'b1;
        ps2_d = 1'b1;
        repeat (30) @(posedge clk);
        send_frame(8'h29, 1'b0, 1'b1, "glitch_29");

        // A start bit sampled as 1 is dropped.
        send_bit(1'b1);
        repeat (60) @(posedge clk);
        send_frame(8'h3B, ~^8'h3B, 1'b1, "badstart_3B");

        send_frame(8'h00, 1'b1, 1'b1, "zero");
        send_frame(8'hFF, 1'b1, 1'b0, "ff_badstop");

        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rp = (~^rb) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 7) != 0);
            send_frame(rb, rp, rs, "rand");
        end

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk);
        resetn   = 1'b0;
        last_acc = 8'h00;
        repeat (3) @(negedge clk);
        check("midreset_key_data", key_data, 0);
        check("midreset_ps2_out", ps2_out, 0);
        check("midreset_pressed", pressed, 0);
        @(posedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        send_frame(8'h1C, 1'b0, 1'b1, "postreset_1C");

        repeat (50) @(posedge clk);
        check("final_pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
